// File: rtl/scan_display_ctrl.sv
// Time-multiplexed scan scheduler for a multi-digit 7-segment display.
// Each digit gets a dark blanking slot followed by a PWM-dimmed dwell slot.
module scan_display_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter bit SEG_INVERT   = 1'b1
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [3:0]                brightness,
    input  logic [7*NUM_DIGITS-1:0]   digit_seg,
    output logic [6:0]                bigseg,
    output logic [NUM_DIGITS-1:0]     sel,
    output logic [2:0]                digit_idx,
    output logic                      frame_start
);

    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [2:0]       LAST_IDX   = 3'(NUM_DIGITS - 1);
    localparam logic [6:0]       INV_MASK   = SEG_INVERT ? 7'h7F : 7'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } state_t;

    state_t                  state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [3:0]              phase_r;
    logic [2:0]              digit_idx_r;
    logic [55:0]             shadow_r;
    logic [6:0]              bigseg_r;
    logic [NUM_DIGITS-1:0]   sel_r;
    logic                    frame_start_r;

    logic [55:0]             seg_pad_s;
    logic [6:0]              pattern_s;
    logic [2:0]              next_idx_s;
    logic [3:0]              next_phase_s;

    function automatic logic [NUM_DIGITS-1:0] onehot_sel(input logic [2:0] idx);
        logic [NUM_DIGITS-1:0] v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            v[i] = (idx == 3'(i));
        end
        return v;
    endfunction

    // Segments are lit while the PWM phase is inside the duty window; 15 means always on.
    function automatic logic pwm_on(input logic [3:0] ph, input logic [3:0] br);
        return (br == 4'd15) || (ph < br);
    endfunction

    // Pattern lookup from the frame snapshot and next-slot bookkeeping.
    always_comb begin
        seg_pad_s    = 56'(digit_seg);
        pattern_s    = shadow_r[7*digit_idx_r +: 7] ^ INV_MASK;
        next_phase_s = phase_r + 4'd1;
        if (digit_idx_r == LAST_IDX) begin
            next_idx_s = 3'd0;
        end else begin
            next_idx_s = digit_idx_r + 3'd1;
        end
    end

    // Scan scheduler: IDLE -> BLANK -> ON -> BLANK(next digit) ..., all outputs registered.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            cnt_r         <= '0;
            phase_r       <= 4'd0;
            digit_idx_r   <= 3'd0;
            shadow_r      <= 56'd0;
            bigseg_r      <= 7'd0;
            sel_r         <= '0;
            frame_start_r <= 1'b0;
        end else if (!enable) begin
            state_r       <= ST_IDLE;
            cnt_r         <= '0;
            phase_r       <= 4'd0;
            digit_idx_r   <= 3'd0;
            bigseg_r      <= 7'd0;
            sel_r         <= '0;
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    state_r       <= ST_BLANK;
                    cnt_r         <= '0;
                    phase_r       <= 4'd0;
                    digit_idx_r   <= 3'd0;
                    shadow_r      <= seg_pad_s;
                    frame_start_r <= 1'b1;
                    bigseg_r      <= 7'd0;
                    sel_r         <= '0;
                end
                ST_BLANK: begin
                    if (cnt_r == BLANK_LAST) begin
                        state_r  <= ST_ON;
                        cnt_r    <= '0;
                        phase_r  <= 4'd0;
                        sel_r    <= onehot_sel(digit_idx_r);
                        bigseg_r <= pwm_on(4'd0, brightness) ? pattern_s : 7'd0;
                    end else begin
                        cnt_r    <= cnt_r + CNT_W'(1);
                        bigseg_r <= 7'd0;
                        sel_r    <= '0;
                    end
                end
                ST_ON: begin
                    if (cnt_r == DWELL_LAST) begin
                        state_r     <= ST_BLANK;
                        cnt_r       <= '0;
                        phase_r     <= 4'd0;
                        digit_idx_r <= next_idx_s;
                        sel_r       <= '0;
                        bigseg_r    <= 7'd0;
                        // Wrapping back to digit 0 starts a new frame with a fresh snapshot.
                        if (next_idx_s == 3'd0) begin
                            frame_start_r <= 1'b1;
                            shadow_r      <= seg_pad_s;
                        end else begin
                            frame_start_r <= 1'b0;
                        end
                    end else begin
                        cnt_r    <= cnt_r + CNT_W'(1);
                        phase_r  <= next_phase_s;
                        bigseg_r <= pwm_on(next_phase_s, brightness) ? pattern_s : 7'd0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= '0;
                    phase_r     <= 4'd0;
                    digit_idx_r <= 3'd0;
                    bigseg_r    <= 7'd0;
                    sel_r       <= '0;
                end
            endcase
        end
    end

    assign bigseg      = bigseg_r;
    assign sel         = sel_r;
    assign digit_idx   = digit_idx_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Self-checking bench for scan_display_ctrl: vector table, directed corner
// sequences and randomized stimulus against a frame-position reference model.
module tb_scan_display_ctrl;

    localparam int ND    = 2;
    localparam int BLANK = 2;
    localparam int DWELL = 16;
    localparam int SLOT  = BLANK + DWELL;
    localparam int FRAME = ND * SLOT;

    logic            CLOCK_50 = 1'b0;
    logic            reset;
    logic            enable;
    logic [3:0]      brightness;
    logic [7*ND-1:0] digit_seg;
    logic [6:0]      bigseg;
    logic [ND-1:0]   sel;
    logic [2:0]      digit_idx;
    logic            frame_start;

    int checks = 0;
    int errors = 0;

    // Reference model: position of the current cycle inside the frame.
    bit          m_active = 1'b0;
    int          m_pos    = 0;
    logic [13:0] m_shadow = 14'd0;
    logic [3:0]  m_br     = 4'd0;
    logic [ND-1:0] prev_sel = '0;

    scan_display_ctrl #(
        .NUM_DIGITS  (ND),
        .DWELL_CYCLES(DWELL),
        .BLANK_CYCLES(BLANK),
        .SEG_INVERT  (1'b1)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .enable     (enable),
        .brightness (brightness),
        .digit_seg  (digit_seg),
        .bigseg     (bigseg),
        .sel        (sel),
        .digit_idx  (digit_idx),
        .frame_start(frame_start)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
        end
    endtask

    task automatic model_edge();
        if (!enable) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_pos    = 0;
            m_shadow = digit_seg;
        end else begin
            m_pos = (m_pos + 1) % FRAME;
            if (m_pos == 0) m_shadow = digit_seg;
        end
        m_br = brightness;
    endtask

    task automatic model_compare();
        logic [ND-1:0] e_sel;
        logic [6:0]    e_seg;
        logic [2:0]    e_idx;
        logic          e_fs;
        int d, q, ph;
        e_sel = '0; e_seg = 7'd0; e_idx = 3'd0; e_fs = 1'b0;
        if (m_active) begin
            d     = m_pos / SLOT;
            q     = m_pos % SLOT;
            e_idx = 3'(d);
            e_fs  = (m_pos == 0);
            if (q >= BLANK) begin
                ph    = (q - BLANK) % 16;
                e_sel = ND'(1 << d);
                if (m_br == 4'd15 || ph < int'(m_br))
                    e_seg = ~m_shadow[7*d +: 7];
            end
        end
        chk("model_sel", 32'(sel), 32'(e_sel));
        chk("model_bigseg", 32'(bigseg), 32'(e_seg));
        chk("model_digit_idx", 32'(digit_idx), 32'(e_idx));
        chk("model_frame_start", 32'(frame_start), 32'(e_fs));
        chk("onehot_sel", 32'($countones(sel) <= 1), 32'd1);
        chk("no_overlap", 32'(prev_sel != '0 && sel != '0 && sel != prev_sel), 32'd0);
        prev_sel = sel;
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        model_edge();
        #1;
        model_compare();
    endtask

    // Advance until the model reaches frame position pos (bounded).
    task automatic seek(input int pos, input string name);
        int n = 0;
        while (!(m_active && m_pos == pos) && n < 4 * FRAME) begin
            step();
            n++;
        end
        chk(name, 32'(m_active && m_pos == pos), 32'd1);
    endtask

    typedef struct {
        logic       en;
        logic [3:0] br;
        int         n;
        logic [1:0] sel;
        logic [6:0] seg;
        logic       fs;
        logic [2:0] idx;
    } vec_t;

    initial begin
        vec_t vecs[7];
        int   lit, on_cnt;

        vecs[0] = '{1'b1, 4'd15,  1, 2'b00, 7'b0000000, 1'b1, 3'd0};
        vecs[1] = '{1'b1, 4'd15,  1, 2'b00, 7'b0000000, 1'b0, 3'd0};
        vecs[2] = '{1'b1, 4'd15, 16, 2'b01, 7'b0000110, 1'b0, 3'd0};
        vecs[3] = '{1'b1, 4'd15,  2, 2'b00, 7'b0000000, 1'b0, 3'd1};
        vecs[4] = '{1'b1, 4'd15, 16, 2'b10, 7'b0111111, 1'b0, 3'd1};
        vecs[5] = '{1'b1, 4'd15,  2, 2'b00, 7'b0000000, 1'b1, 3'd0};
        vecs[6] = '{1'b1, 4'd15, 16, 2'b01, 7'b0000110, 1'b0, 3'd0};

        reset      = 1'b1;
        enable     = 1'b0;
        brightness = 4'd15;
        digit_seg  = {7'b1000000, 7'b1111001};
        repeat (2) @(posedge CLOCK_50);
        #1;
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_bigseg", 32'(bigseg), 32'd0);
        chk("reset_digit_idx", 32'(digit_idx), 32'd0);
        chk("reset_frame_start", 32'(frame_start), 32'd0);
        reset  = 1'b0;
        enable = 1'b1;

        // Timing and segment-data table.
        for (int v = 0; v < 7; v++) begin
            enable     = vecs[v].en;
            brightness = vecs[v].br;
            for (int k = 0; k < vecs[v].n; k++) begin
                step();
                chk("tbl_sel", 32'(sel), 32'(vecs[v].sel));
                chk("tbl_bigseg", 32'(bigseg), 32'(vecs[v].seg));
                chk("tbl_idx", 32'(digit_idx), 32'(vecs[v].idx));
                chk("tbl_fs", 32'(frame_start), 32'(vecs[v].fs && k == 0));
            end
        end

        // Snapshot: change inputs mid digit-0 ON; old values hold until next frame.
        seek(8, "seek_snap");
        digit_seg = {7'b0100100, 7'b0110000};
        step();
        chk("snap_old", 32'(bigseg), 32'(7'b0000110));
        seek(SLOT + 6, "seek_snap_d1");
        chk("snap_old_d1", 32'(bigseg), 32'(7'b0111111));
        seek(5, "seek_snap_new");
        chk("snap_new", 32'(bigseg), 32'(7'b1001111));

        // PWM duty: brightness 4 lights 4 of 16 dwell cycles, brightness 0 none.
        enable = 1'b0;
        step();
        enable     = 1'b1;
        brightness = 4'd4;
        lit = 0; on_cnt = 0;
        for (int k = 0; k < FRAME; k++) begin
            step();
            if (sel == 2'b01) on_cnt++;
            if (sel == 2'b01 && bigseg != 7'd0) lit++;
        end
        chk("pwm4_lit", 32'(lit), 32'd4);
        chk("pwm4_on", 32'(on_cnt), 32'd16);
        brightness = 4'd0;
        lit = 0; on_cnt = 0;
        for (int k = 0; k < FRAME; k++) begin
            step();
            if (sel == 2'b10) on_cnt++;
            if (bigseg != 7'd0) lit++;
        end
        chk("pwm0_lit", 32'(lit), 32'd0);
        chk("pwm0_on", 32'(on_cnt), 32'd16);

        // Enable drop during digit 1 ON, then restart.
        brightness = 4'd15;
        seek(SLOT + 7, "seek_endrop");
        enable = 1'b0;
        step();
        chk("endrop_sel", 32'(sel), 32'd0);
        chk("endrop_bigseg", 32'(bigseg), 32'd0);
        chk("endrop_idx", 32'(digit_idx), 32'd0);
        enable = 1'b1;
        step();
        chk("reen_fs", 32'(frame_start), 32'd1);
        chk("reen_sel", 32'(sel), 32'd0);
        repeat (20) step();

        // Asynchronous reset mid dwell slot, between clock edges.
        seek(10, "seek_areset");
        #2;
        reset = 1'b1;
        #1;
        chk("areset_sel", 32'(sel), 32'd0);
        chk("areset_bigseg", 32'(bigseg), 32'd0);
        chk("areset_fs", 32'(frame_start), 32'd0);
        m_active = 1'b0;
        prev_sel = '0;
        #1;
        reset = 1'b0;
        step();
        chk("areset_restart_fs", 32'(frame_start), 32'd1);
        chk("areset_restart_idx", 32'(digit_idx), 32'd0);
        repeat (40) step();

        // Randomized enable, brightness and pattern changes.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 63) == 0) enable = ~enable;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            if ($urandom_range(0, 7) == 0) brightness = 4'($urandom);
            if ($urandom_range(0, 15) == 0) digit_seg = 14'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_display_ctrl.md
Name: scan_display_ctrl

Overview:
- Time-multiplexing scheduler for an external multi-digit common-segment 7-segment display driven over GPIO.
- Shares one 7-bit segment bus between NUM_DIGITS digits. Each digit gets a blanking slot (anti-ghosting) followed by a dwell slot. During the dwell slot the digit select is active and segments are PWM-dimmed.
- Sits between the bcdto7seg decoders and the GPIO pins. Replaces ad-hoc select toggling driven from counter bits.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- DWELL_CYCLES, 50000, clock cycles a digit is selected (1 ms at 50 MHz); minimum 16.
- BLANK_CYCLES, 500, cycles with all selects off between digits; minimum 1.
- SEG_INVERT, 1, 1 = input patterns are active-low (bcdto7seg format) and the output is active-high; 0 = pass-through polarity.

Ports:
- CLOCK_50  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  1 = scanning; 0 = display dark, scheduler idle.
- brightness  input  4  PWM duty within the dwell slot: 0 = off, 15 = full on.
- digit_seg  input  7*NUM_DIGITS  digit i pattern at bits [7i+6:7i], in bcdto7seg polarity.
- bigseg  output  7  segment bus to GPIO.
- sel  output  NUM_DIGITS  one-hot digit select, active-high.
- digit_idx  output  3  index of the digit currently in its slot.
- frame_start  output  1  one-cycle pulse on the first BLANK cycle of digit 0.

Behaviour:
- All outputs are registered.
- Reset values: bigseg = 0, sel = 0, digit_idx = 0, frame_start = 0, state = IDLE, all counters = 0, shadow register = 0.
- States:
  - IDLE: outputs dark (bigseg = 0, sel = 0).
  - IDLE -> BLANK (digit 0) on the first rising edge with enable = 1. Because outputs are registered, frame_start is asserted during that first BLANK cycle.
  - BLANK: sel = 0 and bigseg = 0 for exactly BLANK_CYCLES cycles, then -> ON.
  - ON: sel = one-hot(digit_idx) for exactly DWELL_CYCLES cycles, then -> BLANK of digit_idx+1.
  - Wrap: after digit NUM_DIGITS-1 the index returns to 0 and frame_start pulses again.
  - Frame period = NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles, with no idle gap between frames.
- Snapshot: digit_seg is captured into the shadow register on the cycle the scheduler enters BLANK of digit 0. Displayed patterns come only from the shadow register, so input changes mid-frame never tear a frame.
- Segment value: pattern = shadow[digit_idx]. It is XOR-inverted when SEG_INVERT = 1.
- PWM:
  - A 4-bit phase counter clears on ON entry and increments every ON cycle, wrapping 15 -> 0.
  - bigseg = pattern when (brightness == 15) or (phase < brightness); otherwise bigseg = 0.
  - sel stays asserted for the whole ON slot regardless of PWM.
  - brightness is sampled every cycle; a change takes effect on the next cycle.
- enable deasserted in any state: next edge -> IDLE with bigseg = 0, sel = 0, digit_idx = 0. The in-flight slot is aborted. Re-enable restarts at BLANK of digit 0 with a new snapshot.
- Overlap guarantee: sel never has more than one bit set. sel is never nonzero in the cycle immediately after a different digit's select was nonzero; at least BLANK_CYCLES dark cycles separate any two digits.
- Reset mid-frame: outputs clear immediately (asynchronously). Scanning resumes at digit 0 after reset releases, if enable = 1.
- Counters:
  - The dwell counter is wide enough for max(DWELL_CYCLES, BLANK_CYCLES).
  - Terminal detection is by equality, so no off-by-one: each slot is exactly N cycles.

Test Plan:
- Timing: NUM_DIGITS=2, BLANK=2, DWELL=16, brightness=15, enable held 1 from reset release -> frame_start pulses every 36 cycles. sel sequence is 00 x2, 01 x16, 00 x2, 10 x16. Never 11.
- Segment data: digit_seg digit0 = 7'b1111001, digit1 = 7'b1000000, SEG_INVERT=1, brightness=15 -> bigseg = 7'b0000110 during digit0 ON, 7'b0111111 during digit1 ON, 0 during BLANK.
- Snapshot: change digit_seg mid-ON of digit0 -> the current frame still shows the old values. The new values appear only after the next frame_start.
- PWM: brightness=4, DWELL=16 -> bigseg nonzero for exactly 4 of 16 ON cycles (phases 0-3). brightness=0 -> bigseg = 0 throughout while sel still cycles.
- Enable drop: deassert enable during digit1 ON -> next cycle sel = 0, bigseg = 0, digit_idx = 0. Reassert -> frame_start in the next cycle and the sequence restarts at digit0 BLANK.
- Async reset: pulse reset mid-ON without a clock edge -> sel, bigseg and frame_start go 0 immediately. After release, scanning restarts from digit 0.
